// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - md_unit operation codes and helpers
package md_unit_pkg;

    localparam int MD_OP_LEN = 3;

    typedef logic [MD_OP_LEN-1:0] md_op_t;

    localparam md_op_t MD_OP_NONE  = 3'd0;
    localparam md_op_t MD_OP_MULT  = 3'd1;
    localparam md_op_t MD_OP_MULTU = 3'd2;
    localparam md_op_t MD_OP_DIV   = 3'd3;
    localparam md_op_t MD_OP_DIVU  = 3'd4;
    localparam md_op_t MD_OP_MTHI  = 3'd5;
    localparam md_op_t MD_OP_MTLO  = 3'd6;

    function automatic logic is_mul_op(input md_op_t op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - issue/result bundle between execute stage and md_unit
interface md_unit_if #(
    parameter int WIDTH = 32
);
    import md_unit_pkg::*;

    logic                 start;
    logic [MD_OP_LEN-1:0] md_op;
    logic [WIDTH-1:0]     in0;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic                 busy;
    logic                 md_active;

    modport master (
        output start, md_op, in0, in1,
        input  hi, lo, busy, md_active
    );

    modport slave (
        input  start, md_op, in0, in1,
        output hi, lo, busy, md_active
    );

endinterface

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational product/quotient/remainder for md_unit
module md_arith
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_we
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic signed [2*WIDTH-1:0] sprod;
    logic        [2*WIDTH-1:0] uprod;
    logic                      div_zero;
    logic                      div_ovf;
    logic        [WIDTH-1:0]   sdiv_b;
    logic        [WIDTH-1:0]   udiv_b;
    logic signed [WIDTH-1:0]   sq;
    logic signed [WIDTH-1:0]   sr;
    logic        [WIDTH-1:0]   uq;
    logic        [WIDTH-1:0]   ur;

    assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Dividing by 1 instead of -1 yields exactly the wrapped most-negative
    // quotient with zero remainder, so overflow needs no separate result path.
    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == {WIDTH{1'b1}});
    assign sdiv_b   = (div_zero || div_ovf) ? ONE : b;
    assign udiv_b   = div_zero ? ONE : b;

    assign sq = $signed(a) / $signed(sdiv_b);
    assign sr = $signed(a) % $signed(sdiv_b);
    assign uq = a / udiv_b;
    assign ur = a % udiv_b;

    // Select the hi/lo pair for the latched op; divide by zero suppresses the write.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b0;
        case (op)
            MD_OP_MULT: begin
                res_hi = sprod[2*WIDTH-1:WIDTH];
                res_lo = sprod[WIDTH-1:0];
                res_we = 1'b1;
            end
            MD_OP_MULTU: begin
                res_hi = uprod[2*WIDTH-1:WIDTH];
                res_lo = uprod[WIDTH-1:0];
                res_we = 1'b1;
            end
            MD_OP_DIV: begin
                res_hi = sr;
                res_lo = sq;
                res_we = !div_zero;
            end
            MD_OP_DIVU: begin
                res_hi = ur;
                res_lo = uq;
                res_we = !div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic    clk,
    input  logic    reset,
    md_unit_if.slave bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    md_op_t           op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_we;

    assign state = (cnt != '0) ? ST_RUN : ST_IDLE;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .res_we (res_we)
    );

    // Issue in IDLE, count down in RUN, commit hi/lo on the last busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            op_q <= MD_OP_NONE;
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_mul_op(bus.md_op) || is_div_op(bus.md_op)) begin
                            op_q <= bus.md_op;
                            a_q  <= bus.in0;
                            b_q  <= bus.in1;
                            cnt  <= is_mul_op(bus.md_op) ? MULT_CNT : DIV_CNT;
                        end else if (bus.md_op == MD_OP_MTHI) begin
                            hi_q <= bus.in0;
                        end else if (bus.md_op == MD_OP_MTLO) begin
                            lo_q <= bus.in0;
                        end
                    end
                end
                default: begin
                    if (cnt == CNT_ONE) begin
                        if (res_we) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        cnt <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = (state == ST_RUN);
    assign bus.md_active = bus.start || (state == ST_RUN);

endmodule
